rice_core_id_stage: RTL

- Instruction-decode stage of the rice core pipeline; sits between the fetch stage and the execute stage.
- Decodes one RV32I instruction per cycle and reads rs1/rs2 from the integer register file it owns.
- Accepts write-back from the stage after execute.
- Registers a decode result that the execute stage consumes; honours execute-stage stall and flush.

---
 rtl/rice_core_pkg.sv | 22 ++
 rtl/rice_core_id_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_core_pkg.sv
// Shared rice core pipeline types: ALU operation, memory access and CSR access encodings.
package rice_core_pkg;

  typedef enum logic [4:0] {
    AluNone, AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd,
    AluAddi, AluSlti, AluSltiu, AluXori, AluOri, AluAndi, AluSlli, AluSrli, AluSrai,
    AluLui, AluAuipc
  } rice_core_alu_operation;

  typedef enum logic [1:0] {MemNone, MemLoad, MemStore} rice_core_memory_access_type;

  typedef struct packed {
    rice_core_memory_access_type access_type;
    logic [1:0]                  access_size;   // 0: byte, 1: half, 2: word
    logic                        access_signed;
  } rice_core_memory_access;

  typedef enum logic [2:0] {
    CsrNone, CsrRw, CsrRs, CsrRc, CsrRwi, CsrRsi, CsrRci
  } rice_core_csr_access;

endpackage

// File: rtl/rice_core_id_stage.sv
// RV32I decode stage: combinational decode, owned register file with write-back bypass, output
// register with flush/stall. Define RICE_CORE_RV32E_EN for a 16-entry RV32E register file.
module rice_core_id_stage
  import rice_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_if_valid,
  input  logic [XLEN-1:0]        i_if_pc,
  input  logic [31:0]            i_if_inst,
  output logic                   o_if_stall,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_wb_valid,
  input  logic [4:0]             i_wb_rd,
  input  logic [XLEN-1:0]        i_wb_value,
  output logic                   o_id_valid,
  output logic [XLEN-1:0]        o_pc,
  output logic [4:0]             o_rs1,
  output logic [4:0]             o_rs2,
  output logic [4:0]             o_rd,
  output logic [XLEN-1:0]        o_rs1_value,
  output logic [XLEN-1:0]        o_rs2_value,
  output logic [XLEN-1:0]        o_imm_value,
  output rice_core_alu_operation o_alu_operation,
  output logic [1:0]             o_jamp_operation,
  output logic [1:0]             o_branch_operation,
  output rice_core_memory_access o_memory_access,
  output rice_core_csr_access    o_csr_access,
  output logic                   o_illegal
);

`ifdef RICE_CORE_RV32E_EN
  localparam int unsigned RegAw = 4;
`else
  localparam int unsigned RegAw = 5;
`endif
  localparam int unsigned NumRegs = 2 ** RegAw;

  // Register file
  logic [XLEN-1:0] rf_q [NumRegs];
  logic            wb_we;

`ifdef RICE_CORE_RV32E_EN
  assign wb_we = i_wb_valid && (i_wb_rd != 5'd0) && !i_wb_rd[4];
`else
  assign wb_we = i_wb_valid && (i_wb_rd != 5'd0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[i_wb_rd[RegAw-1:0]] <= i_wb_value;
    end
  end

  // Decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = i_if_inst[6:0];
  assign funct3 = i_if_inst[14:12];
  assign funct7 = i_if_inst[31:25];

  rice_core_alu_operation alu_d;
  rice_core_memory_access mem_d;
  rice_core_csr_access    csr_d;
  logic [1:0]             jump_d, branch_d;
  logic                   rd_use, rs1_use, rs2_use, illegal_d, imm_zext;
  logic [31:0]            imm32;
  logic [4:0]             rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]        imm_d;

  always_comb begin
    alu_d     = AluNone;
    mem_d     = '{access_type: MemNone, access_size: 2'b00, access_signed: 1'b0};
    csr_d     = CsrNone;
    jump_d    = 2'b00;
    branch_d  = 2'b00;
    rd_use    = 1'b0;
    rs1_use   = 1'b0;
    rs2_use   = 1'b0;
    illegal_d = 1'b0;
    imm_zext  = 1'b0;
    imm32     = '0;
    unique case (opcode)
      7'b0110111: begin
        alu_d  = AluLui;
        rd_use = 1'b1;
        imm32  = {i_if_inst[31:12], 12'b0};
      end
      7'b0010111: begin
        alu_d  = AluAuipc;
        rd_use = 1'b1;
        imm32  = {i_if_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        jump_d = 2'b01;
        rd_use = 1'b1;
        imm32  = {{12{i_if_inst[31]}}, i_if_inst[19:12], i_if_inst[20], i_if_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        jump_d    = 2'b10;
        rd_use    = 1'b1;
        rs1_use   = 1'b1;
        imm32     = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        illegal_d = (funct3 != 3'b000);
      end
      7'b1100011: begin
        // The ALU produces a compare result; ne_lt takes on non-zero, eq_ge takes on zero.
        rs1_use = 1'b1;
        rs2_use = 1'b1;
        imm32   = {{20{i_if_inst[31]}}, i_if_inst[7], i_if_inst[30:25], i_if_inst[11:8], 1'b0};
        unique case (funct3)
          3'b000:  begin alu_d = AluSub;  branch_d = 2'b01; end
          3'b001:  begin alu_d = AluSub;  branch_d = 2'b10; end
          3'b100:  begin alu_d = AluSlt;  branch_d = 2'b10; end
          3'b101:  begin alu_d = AluSlt;  branch_d = 2'b01; end
          3'b110:  begin alu_d = AluSltu; branch_d = 2'b10; end
          3'b111:  begin alu_d = AluSltu; branch_d = 2'b01; end
          default: illegal_d = 1'b1;
        endcase
      end
      7'b0000011: begin
        alu_d     = AluAddi;
        rd_use    = 1'b1;
        rs1_use   = 1'b1;
        imm32     = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        mem_d     = '{access_type: MemLoad, access_size: funct3[1:0], access_signed: !funct3[2]};
        illegal_d = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
      end
      7'b0100011: begin
        alu_d     = AluAddi;
        rs1_use   = 1'b1;
        rs2_use   = 1'b1;
        imm32     = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
        mem_d     = '{access_type: MemStore, access_size: funct3[1:0], access_signed: 1'b0};
        illegal_d = funct3[2] || (funct3[1:0] == 2'b11);
      end
      7'b0010011: begin
        rd_use  = 1'b1;
        rs1_use = 1'b1;
        imm32   = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        unique case (funct3)
          3'b000: alu_d = AluAddi;
          3'b010: alu_d = AluSlti;
          3'b011: alu_d = AluSltiu;
          3'b100: alu_d = AluXori;
          3'b110: alu_d = AluOri;
          3'b111: alu_d = AluAndi;
          3'b001: begin
            alu_d     = AluSlli;
            illegal_d = (funct7 != 7'b0000000);
          end
          default: begin
            alu_d     = (funct7 == 7'b0100000) ? AluSrai : AluSrli;
            illegal_d = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      7'b0110011: begin
        rd_use  = 1'b1;
        rs1_use = 1'b1;
        rs2_use = 1'b1;
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000:  alu_d = AluAdd;
            3'b001:  alu_d = AluSll;
            3'b010:  alu_d = AluSlt;
            3'b011:  alu_d = AluSltu;
            3'b100:  alu_d = AluXor;
            3'b101:  alu_d = AluSrl;
            3'b110:  alu_d = AluOr;
            default: alu_d = AluAnd;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_d = AluSub;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          alu_d = AluSra;
        end else begin
          illegal_d = 1'b1;
        end
      end
      7'b0001111: ;  // FENCE: no architectural effect in this in-order core
      7'b1110011: begin
        // CSR address in bits 31:20, zimm (immediate forms only) in bits 4:0.
        rd_use   = 1'b1;
        rs1_use  = !funct3[2];
        imm_zext = 1'b1;
        imm32    = {i_if_inst[31:20], 15'b0, funct3[2] ? i_if_inst[19:15] : 5'b0};
        unique case (funct3)
          3'b001:  csr_d = CsrRw;
          3'b010:  csr_d = CsrRs;
          3'b011:  csr_d = CsrRc;
          3'b101:  csr_d = CsrRwi;
          3'b110:  csr_d = CsrRsi;
          3'b111:  csr_d = CsrRci;
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
`ifdef RICE_CORE_RV32E_EN
    if ((rd_use && i_if_inst[11]) || (rs1_use && i_if_inst[19]) || (rs2_use && i_if_inst[24])) begin
      illegal_d = 1'b1;
    end
`endif
    if (illegal_d) begin
      alu_d    = AluNone;
      mem_d    = '{access_type: MemNone, access_size: 2'b00, access_signed: 1'b0};
      csr_d    = CsrNone;
      jump_d   = 2'b00;
      branch_d = 2'b00;
      rd_use   = 1'b0;
      rs1_use  = 1'b0;
      rs2_use  = 1'b0;
    end
  end

  assign rd_d  = rd_use  ? i_if_inst[11:7]  : 5'd0;
  assign rs1_d = rs1_use ? i_if_inst[19:15] : 5'd0;
  assign rs2_d = rs2_use ? i_if_inst[24:20] : 5'd0;

  always_comb begin
    if (imm_zext) imm_d = XLEN'(imm32);
    else          imm_d = XLEN'($signed(imm32));
  end

  // Register read with same-cycle write-back bypass
  logic [XLEN-1:0] rs1_rdata, rs2_rdata;

  always_comb begin
    rs1_rdata = '0;
    rs2_rdata = '0;
    if (rs1_d != 5'd0) begin
      rs1_rdata = (wb_we && i_wb_rd == rs1_d) ? i_wb_value : rf_q[rs1_d[RegAw-1:0]];
    end
    if (rs2_d != 5'd0) begin
      rs2_rdata = (wb_we && i_wb_rd == rs2_d) ? i_wb_value : rf_q[rs2_d[RegAw-1:0]];
    end
  end

  // Output register
  logic load_en;
  assign load_en    = i_enable && !i_flush && !i_stall;
  assign o_if_stall = i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_id_valid         <= 1'b0;
      o_pc               <= '0;
      o_rs1              <= '0;
      o_rs2              <= '0;
      o_rd               <= '0;
      o_rs1_value        <= '0;
      o_rs2_value        <= '0;
      o_imm_value        <= '0;
      o_alu_operation    <= AluNone;
      o_jamp_operation   <= '0;
      o_branch_operation <= '0;
      o_memory_access    <= '{access_type: MemNone, access_size: 2'b00, access_signed: 1'b0};
      o_csr_access       <= CsrNone;
      o_illegal          <= 1'b0;
    end else begin
      if (!i_enable || i_flush) o_id_valid <= 1'b0;
      else if (!i_stall)        o_id_valid <= i_if_valid;
      if (load_en) begin
        o_pc               <= i_if_pc;
        o_rs1              <= rs1_d;
        o_rs2              <= rs2_d;
        o_rd               <= rd_d;
        o_rs1_value        <= rs1_rdata;
        o_rs2_value        <= rs2_rdata;
        o_imm_value        <= imm_d;
        o_alu_operation    <= alu_d;
        o_jamp_operation   <= jump_d;
        o_branch_operation <= branch_d;
        o_memory_access    <= mem_d;
        o_csr_access       <= csr_d;
        o_illegal          <= illegal_d;
      end else begin
        // Held operands track write-back so a long stall never releases stale data.
        if (wb_we && i_wb_rd == o_rs1) o_rs1_value <= i_wb_value;
        if (wb_we && i_wb_rd == o_rs2) o_rs2_value <= i_wb_value;
      end
    end
  end

endmodule
